// File: rtl/spi_pkg.sv
// Shared SPI link definitions.
// Used by the master and the matching receiver.
package spi_pkg;

  localparam int SPI_WIDTH = 16;
  localparam bit SPI_CS_ACTIVE_HIGH = 1'b1;
  localparam int HP_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL,
    GAP
  } spi_state_e;

  function automatic logic [HP_W-1:0] hp_reload(input int div);
    return HP_W'(div - 1);
  endfunction

endpackage

// File: rtl/spi_halfperiod_timer.sv
// Loadable down-counter for SCLK half-periods.
// tick_o is high on the last cycle of a phase.
module spi_halfperiod_timer
  import spi_pkg::*;
#(
  parameter int W = HP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Reload on phase entry, otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master_tx.sv
// SPI initiator: shifts words out MSB-first on MOSI
// and returns the word captured from MISO.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH,
  parameter int CLK_DIV = 4,
  parameter bit CS_ACTIVE_HIGH = SPI_CS_ACTIVE_HIGH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             sclk_o,
  output logic             cs_o,
  output logic             mosi_o,
  input  logic             miso_i
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [HP_W-1:0] RELOAD = hp_reload(CLK_DIV);

  spi_state_e state_q, state_d;

  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             rx_valid_q, rx_valid_d;
  logic             busy_q, busy_d;
  logic             tx_ready_q, tx_ready_d;
  logic             sclk_q, sclk_d;
  logic             cs_act_q, cs_act_d;
  logic             mosi_q, mosi_d;

  logic hs;
  logic hp_tick;
  logic hp_load;

  assign hs = tx_valid && tx_ready_q;

  // Every state entry restarts a full half-period;
  // IDLE keeps the timer primed for LEAD.
  assign hp_load = (state_d != state_q) || (state_q == IDLE);

  spi_halfperiod_timer #(
    .W(HP_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (hp_load),
    .load_val_i(RELOAD),
    .tick_o    (hp_tick)
  );

  // Frame sequencer: next state and next register values.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    tx_ready_d = tx_ready_q;
    sclk_d     = sclk_q;
    cs_act_d   = cs_act_q;
    mosi_d     = mosi_q;

    unique case (state_q)
      IDLE: begin
        tx_ready_d = 1'b1;
        if (hs) begin
          tx_shift_d = tx_data;
          bit_cnt_d  = '0;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
          cs_act_d   = 1'b1;
          mosi_d     = tx_data[WIDTH-1];
          state_d    = LEAD;
        end
      end
      LEAD: begin
        if (hp_tick) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (hp_tick) begin
          rx_shift_d = {rx_shift_q[WIDTH-2:0], miso_i};
          sclk_d     = 1'b0;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = TRAIL;
          end else begin
            bit_cnt_d  = bit_cnt_q + CW'(1);
            tx_shift_d = tx_shift_q << 1;
            mosi_d     = tx_shift_d[WIDTH-1];
            state_d    = LOW;
          end
        end
      end
      LOW: begin
        if (hp_tick) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      TRAIL: begin
        if (hp_tick) begin
          cs_act_d   = 1'b0;
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (hp_tick) begin
          busy_d     = 1'b0;
          tx_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and pin registers; reset aborts any frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      sclk_q     <= 1'b0;
      cs_act_q   <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
      sclk_q     <= sclk_d;
      cs_act_q   <= cs_act_d;
      mosi_q     <= mosi_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign sclk_o   = sclk_q;
  assign cs_o     = CS_ACTIVE_HIGH ? cs_act_q : ~cs_act_q;
  assign mosi_o   = mosi_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: DUT0 CLK_DIV=4 active-high CS,
// DUT1 CLK_DIV=1 active-low CS, behavioural SPI receivers.
module tb_spi_master_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] td[2];
  logic        tv[2];

  logic        tr0, rv0, bz0, sc0, cs0, mo0;
  logic        tr1, rv1, bz1, sc1, cs1, mo1;
  logic [15:0] rd0, rd1;
  logic        mi0 = 1'b0;
  logic        mi1 = 1'b0;

  spi_master_tx #(.WIDTH(16), .CLK_DIV(4), .CS_ACTIVE_HIGH(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(td[0]), .tx_valid(tv[0]),
    .tx_ready(tr0), .rx_data(rd0), .rx_valid(rv0), .busy(bz0),
    .sclk_o(sc0), .cs_o(cs0), .mosi_o(mo0), .miso_i(mi0)
  );

  spi_master_tx #(.WIDTH(16), .CLK_DIV(1), .CS_ACTIVE_HIGH(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(td[1]), .tx_valid(tv[1]),
    .tx_ready(tr1), .rx_data(rd1), .rx_valid(rv1), .busy(bz1),
    .sclk_o(sc1), .cs_o(cs1), .mosi_o(mo1), .miso_i(mi1)
  );

  // Receiver models: on rising SCLK put a bit on MISO
  // (0 / echo of MOSI / random) and remember what was sent.
  int mode0 = 0;
  int mode1 = 0;
  logic [15:0] mexp0 = '0;
  logic [15:0] mexp1 = '0;

  always @(posedge sc0) begin
    if (mode0 == 1) mi0 = mo0;
    else if (mode0 == 2) mi0 = 1'($urandom);
    else mi0 = 1'b0;
    mexp0 = {mexp0[14:0], mi0};
  end

  always @(posedge sc1) begin
    if (mode1 == 1) mi1 = mo1;
    else if (mode1 == 2) mi1 = 1'($urandom);
    else mi1 = 1'b0;
    mexp1 = {mexp1[14:0], mi1};
  end

  logic sc[2], csa[2], mo[2], rv[2], trw[2], bzw[2];
  logic [15:0] rd[2];
  assign sc[0] = sc0;   assign sc[1] = sc1;
  assign csa[0] = cs0;  assign csa[1] = ~cs1;
  assign mo[0] = mo0;   assign mo[1] = mo1;
  assign rv[0] = rv0;   assign rv[1] = rv1;
  assign trw[0] = tr0;  assign trw[1] = tr1;
  assign bzw[0] = bz0;  assign bzw[1] = bz1;
  assign rd[0] = rd0;   assign rd[1] = rd1;

  // Pin monitor sampled on the falling clock edge.
  int cyc = 0;
  int rise[2], csc[2], csf[2], gap[2], lgap[2], cur[2], llen[2];
  int viol[2], rxc[2], fr[2], lr[2];
  logic [31:0] mw[2];
  logic [15:0] rxl[2];
  logic psc[2], pcs[2], pmo[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rise[i] = 0; csc[i] = 0; csf[i] = 0; gap[i] = 0;
      lgap[i] = 0; cur[i] = 0; llen[i] = 0; viol[i] = 0;
      rxc[i] = 0; fr[i] = -1; lr[i] = 0; mw[i] = '0;
      rxl[i] = '0; psc[i] = 1'b0; pcs[i] = 1'b0; pmo[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (csa[i]) begin
        csc[i]++;
        if (!pcs[i]) begin
          csf[i]++;
          lgap[i] = gap[i];
          gap[i] = 0;
          cur[i] = 0;
          fr[i] = -1;
        end
        cur[i]++;
      end else begin
        gap[i]++;
        if (pcs[i]) llen[i] = cur[i];
      end
      if (sc[i] && !psc[i]) begin
        rise[i]++;
        mw[i] = {mw[i][30:0], mo[i]};
        if (fr[i] < 0) fr[i] = cyc;
        lr[i] = cyc;
      end
      if (sc[i] && psc[i] && (mo[i] !== pmo[i])) viol[i]++;
      if (sc[i] && !csa[i]) viol[i]++;
      if (trw[i] && bzw[i]) viol[i]++;
      if (rv[i]) begin
        rxc[i]++;
        rxl[i] = rd[i];
      end
      psc[i] = sc[i];
      pcs[i] = csa[i];
      pmo[i] = mo[i];
    end
  end

  int errs = 0;
  int chks = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present a word and return just after it has been accepted.
  task automatic send(input int i, input logic [15:0] w);
    int n;
    n = 0;
    tv[i] = 1'b1;
    td[i] = w;
    while (!trw[i] && n < 2000) begin
      tick();
      n++;
    end
    chks++;
    if (n >= 2000) begin
      errs++;
      $display("FAIL send_timeout dut%0d: ready=%b required=1", i, trw[i]);
    end
    tick();
    tv[i] = 1'b0;
    td[i] = 16'($urandom);
  endtask

  // Wait for the next rx_valid; lat counts the accept cycle as 1.
  task automatic wait_rx(input int i, output int lat);
    int k, s;
    k = 0;
    s = rxc[i];
    while (rxc[i] == s && k < 3000) begin
      tick();
      k++;
    end
    lat = k + 1;
    chks++;
    if (k >= 3000) begin
      errs++;
      $display("FAIL rx_timeout dut%0d: rx_valid count=%0d required=%0d", i, rxc[i], s + 1);
    end
  endtask

  task automatic test_reset();
    int r0, f0;
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chks++;
    if ({sc0, cs0, mo0, rv0, bz0, tr0, rd0} !== 22'd0) begin
      errs++;
      $display("FAIL reset_outs0: got %h required 0",
               {sc0, cs0, mo0, rv0, bz0, tr0, rd0});
    end
    chks++;
    if ({sc1, cs1, mo1, rv1, bz1, tr1, rd1} !== {1'b0, 1'b1, 20'd0}) begin
      errs++;
      $display("FAIL reset_outs1: got %h required %h",
               {sc1, cs1, mo1, rv1, bz1, tr1, rd1}, {1'b0, 1'b1, 20'd0});
    end
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chks++;
    if (tr0 !== 1'b0) begin
      errs++;
      $display("FAIL ready_before_edge: got %b required 0", tr0);
    end
    @(posedge clk);
    #1;
    chks++;
    if ({tr0, tr1} !== 2'b11) begin
      errs++;
      $display("FAIL ready_after_edge: got %b required 11", {tr0, tr1});
    end
    r0 = rise[0] + rise[1];
    f0 = csf[0] + csf[1];
    repeat (100) tick();
    chks++;
    if ((rise[0] + rise[1] - r0) != 0 || (csf[0] + csf[1] - f0) != 0 ||
        sc0 !== 1'b0 || cs0 !== 1'b0 || cs1 !== 1'b1) begin
      errs++;
      $display("FAIL idle_static: rises=%0d frames=%0d required 0 and 0",
               rise[0] + rise[1] - r0, csf[0] + csf[1] - f0);
    end
  endtask

  task automatic test_single();
    int r0, c0, x0, v0, lat;
    mode0 = 1;
    r0 = rise[0]; c0 = csc[0]; x0 = rxc[0]; v0 = viol[0];
    send(0, 16'hA5C3);
    wait_rx(0, lat);
    tick();
    chks++;
    if (rise[0] - r0 != 16) begin
      errs++;
      $display("FAIL single_rises: got %0d required 16", rise[0] - r0);
    end
    chks++;
    if (mw[0][15:0] !== 16'hA5C3) begin
      errs++;
      $display("FAIL single_mosi: got %h required a5c3", mw[0][15:0]);
    end
    chks++;
    if (csc[0] - c0 != 132 || llen[0] != 132) begin
      errs++;
      $display("FAIL single_cs_len: got %0d/%0d required 132", csc[0] - c0, llen[0]);
    end
    chks++;
    if (rxc[0] - x0 != 1 || rxl[0] !== 16'hA5C3) begin
      errs++;
      $display("FAIL single_rx: pulses=%0d data=%h required 1 and a5c3",
               rxc[0] - x0, rxl[0]);
    end
    chks++;
    if (lat != 133) begin
      errs++;
      $display("FAIL single_latency: got %0d required 133", lat);
    end
    chks++;
    if (viol[0] != v0) begin
      errs++;
      $display("FAIL single_protocol: violations=%0d required 0", viol[0] - v0);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    int r0, lat;
    mode0 = 2;
    for (int n = 0; n < 4; n++) begin
      w = 16'($urandom);
      r0 = rise[0];
      send(0, w);
      wait_rx(0, lat);
      chks++;
      if (mw[0][15:0] !== w || rise[0] - r0 != 16) begin
        errs++;
        $display("FAIL rand_mosi[%0d]: got %h/%0d required %h/16",
                 n, mw[0][15:0], rise[0] - r0, w);
      end
      chks++;
      if (rxl[0] !== mexp0) begin
        errs++;
        $display("FAIL rand_miso[%0d]: got %h required %h", n, rxl[0], mexp0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int r0, f0, x0, c0, v0, n;
    mode0 = 0;
    repeat (10) tick();
    r0 = rise[0]; f0 = csf[0]; x0 = rxc[0]; c0 = csc[0]; v0 = viol[0];
    tv[0] = 1'b1;
    td[0] = 16'h0001;
    n = 0;
    while (!tr0 && n < 2000) begin tick(); n++; end
    tick();
    td[0] = 16'hFFFF;
    while (!tr0 && n < 4000) begin tick(); n++; end
    tick();
    tv[0] = 1'b0;
    while (rxc[0] - x0 < 2 && n < 6000) begin tick(); n++; end
    chks++;
    if (csf[0] - f0 != 2 || rxc[0] - x0 != 2) begin
      errs++;
      $display("FAIL b2b_frames: frames=%0d rx=%0d required 2 and 2",
               csf[0] - f0, rxc[0] - x0);
    end
    chks++;
    if (mw[0] !== 32'h0001FFFF || rise[0] - r0 != 32) begin
      errs++;
      $display("FAIL b2b_mosi: got %h/%0d required 0001ffff/32", mw[0], rise[0] - r0);
    end
    chks++;
    if (lgap[0] < 4) begin
      errs++;
      $display("FAIL b2b_gap: got %0d required >=4", lgap[0]);
    end
    chks++;
    if (rxl[0] !== 16'h0000 || csc[0] - c0 != 264) begin
      errs++;
      $display("FAIL b2b_rx: data=%h cs=%0d required 0000 and 264", rxl[0], csc[0] - c0);
    end
    chks++;
    if (viol[0] != v0) begin
      errs++;
      $display("FAIL b2b_protocol: violations=%0d required 0", viol[0] - v0);
    end
  endtask

  task automatic test_div1();
    int r0, c0, v0, lat;
    mode1 = 1;
    r0 = rise[1]; c0 = csc[1]; v0 = viol[1];
    send(1, 16'h8001);
    wait_rx(1, lat);
    tick();
    chks++;
    if (rise[1] - r0 != 16 || mw[1][15:0] !== 16'h8001) begin
      errs++;
      $display("FAIL div1_mosi: got %h/%0d required 8001/16", mw[1][15:0], rise[1] - r0);
    end
    chks++;
    if (lr[1] - fr[1] != 30) begin
      errs++;
      $display("FAIL div1_period: span=%0d required 30", lr[1] - fr[1]);
    end
    chks++;
    if (csc[1] - c0 != 33 || llen[1] != 33) begin
      errs++;
      $display("FAIL div1_cs_len: got %0d/%0d required 33", csc[1] - c0, llen[1]);
    end
    chks++;
    if (rxl[1] !== 16'h8001 || lat != 34) begin
      errs++;
      $display("FAIL div1_rx: data=%h lat=%0d required 8001 and 34", rxl[1], lat);
    end
    chks++;
    if (viol[1] != v0) begin
      errs++;
      $display("FAIL div1_protocol: violations=%0d required 0", viol[1] - v0);
    end
  endtask

  task automatic test_abort();
    int r0, x0, n, lat;
    mode0 = 1;
    r0 = rise[0];
    x0 = rxc[0];
    send(0, 16'hC3A5);
    n = 0;
    while (rise[0] - r0 < 7 && n < 500) begin tick(); n++; end
    rst = 1'b1;
    #1;
    chks++;
    if (cs0 !== 1'b0 || sc0 !== 1'b0 || n >= 500) begin
      errs++;
      $display("FAIL abort_pins: cs=%b sclk=%b required 0 and 0", cs0, sc0);
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (40) tick();
    chks++;
    if (rxc[0] != x0 || rd0 !== 16'h0000) begin
      errs++;
      $display("FAIL abort_rx: pulses=%0d data=%h required 0 and 0000",
               rxc[0] - x0, rd0);
    end
    r0 = rise[0];
    send(0, 16'h1234);
    wait_rx(0, lat);
    chks++;
    if (rxl[0] !== 16'h1234 || mw[0][15:0] !== 16'h1234 || rise[0] - r0 != 16) begin
      errs++;
      $display("FAIL abort_next: rx=%h mosi=%h rises=%0d required 1234 1234 16",
               rxl[0], mw[0][15:0], rise[0] - r0);
    end
  endtask

  task automatic test_ignore_busy();
    logic [15:0] w;
    int r0, f0, x0, lat;
    mode0 = 2;
    w = 16'($urandom);
    r0 = rise[0]; f0 = csf[0]; x0 = rxc[0];
    send(0, w);
    repeat (20) tick();
    tv[0] = 1'b1;
    td[0] = 16'hDEAD;
    tick();
    tv[0] = 1'b0;
    wait_rx(0, lat);
    repeat (60) tick();
    chks++;
    if (csf[0] - f0 != 1 || rise[0] - r0 != 16 || rxc[0] - x0 != 1) begin
      errs++;
      $display("FAIL busy_ignore: frames=%0d rises=%0d rx=%0d required 1 16 1",
               csf[0] - f0, rise[0] - r0, rxc[0] - x0);
    end
    chks++;
    if (mw[0][15:0] !== w || rxl[0] !== mexp0) begin
      errs++;
      $display("FAIL busy_word: mosi=%h rx=%h required %h %h",
               mw[0][15:0], rxl[0], w, mexp0);
    end
    chks++;
    if (bz0 !== 1'b0 || tr0 !== 1'b1) begin
      errs++;
      $display("FAIL busy_idle: busy=%b ready=%b required 0 and 1", bz0, tr0);
    end
  endtask

  initial begin
    tv[0] = 1'b0; tv[1] = 1'b0;
    td[0] = '0;   td[1] = '0;
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_div1();
    test_abort();
    test_ignore_busy();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
